// File: rtl/output_result_framer.sv
// Wraps a payload stream into frames: MAGIC, info word, payload, checksum trailer.
// One registered output stage feeds the DMA side; payload passes through with one cycle of latency.
module output_result_framer #(
    parameter int unsigned     DW          = 16,
    parameter int unsigned     PAYLOAD_LEN = 512,
    parameter logic [DW-1:0]   MAGIC       = DW'(16'hA55A)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [2:0]    batch_id,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          frame_done,
    output logic          len_error,
    output logic          busy
);

    localparam int unsigned    CW    = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CW-1:0]  LEN_C = CW'(PAYLOAD_LEN);

    typedef enum logic [2:0] {IDLE, HDR1, PAY, TRL, FIN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    seq_q, seq_d;
    logic [2:0]    batch_q, batch_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] csum_q, csum_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          frame_done_q, frame_done_d;
    logic          len_error_q, len_error_d;
    logic          s_ready_c;
    logic          stage_free_c;
    logic [CW-1:0] count_inc_c;
    logic          at_len_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            batch_q      <= '0;
            count_q      <= '0;
            csum_q       <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            len_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            batch_q      <= batch_d;
            count_q      <= count_d;
            csum_q       <= csum_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            len_error_q  <= len_error_d;
        end
    end

    // Next-state and output-stage loading; the stage holds unless explicitly reloaded.
    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        batch_d      = batch_q;
        count_d      = count_q;
        csum_d       = csum_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        frame_done_d = 1'b0;
        len_error_d  = len_error_q;
        s_ready_c    = 1'b0;
        stage_free_c = !m_valid_q || m_axis_tready;
        count_inc_c  = count_q + CW'(1);
        at_len_c     = (count_inc_c == LEN_C);

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable && s_axis_tvalid) begin
                    m_data_d  = MAGIC;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    batch_d   = batch_id;
                    count_d   = '0;
                    csum_d    = '0;
                    state_d   = HDR1;
                end
            end
            HDR1: begin
                if (stage_free_c) begin
                    m_data_d  = DW'({seq_q, 5'b0, batch_q});
                    m_valid_d = 1'b1;
                    state_d   = PAY;
                end
            end
            PAY: begin
                s_ready_c = stage_free_c;
                if (stage_free_c && s_axis_tvalid) begin
                    m_data_d  = s_axis_tdata;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    count_d   = count_inc_c;
                    csum_d    = csum_q + s_axis_tdata;
                    if (s_axis_tlast || at_len_c) begin
                        state_d = TRL;
                    end
                    // Early tlast or missing tlast at the nominal length both count as mismatch.
                    if (s_axis_tlast != at_len_c) begin
                        len_error_d = 1'b1;
                    end
                end
            end
            TRL: begin
                if (stage_free_c) begin
                    m_data_d  = csum_q;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    state_d   = FIN;
                end
            end
            FIN: begin
                if (m_valid_q && m_axis_tready) begin
                    m_last_d     = 1'b0;
                    frame_done_d = 1'b1;
                    seq_d        = seq_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign frame_done    = frame_done_q;
    assign len_error     = len_error_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/output_result_framer.md
OUTPUT_RESULT_FRAMER -- requirements
Module: output_result_framer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning stream data width.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 512, meaning nominal payload words per frame (range 2..1023).
REQ-003 SHALL have parameter MAGIC, default 16'hA55A, meaning header word 0 value.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable  input  1  permits starting a new frame.
REQ-007 SHALL have port batch_id  input  3  batch number to tag, sampled at frame start.
REQ-008 SHALL have ports s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DW/1/1/1  payload from the output stream manager.
REQ-009 SHALL have ports m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DW/1/1/1  framed stream to DMA S2MM.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on trailer handshake.
REQ-011 SHALL have port len_error  output  1  sticky payload-length mismatch flag.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL emit each frame as MAGIC, then info word {seq[7:0], 5'b0, batch_id[2:0]}, then payload words, then checksum word with m_axis_tlast=1 only on the checksum word.
REQ-014 SHALL use states IDLE, HDR1, PAY, TRL, FIN, with a single registered output stage holding m_axis_tdata/tvalid/tlast; the stage is free when !m_axis_tvalid || m_axis_tready.
REQ-015 IDLE: when enable && s_axis_tvalid, SHALL load MAGIC into the output stage, latch batch_id, clear the count and checksum, and go to HDR1.
REQ-016 HDR1: when the stage is free, SHALL load the info word and go to PAY.
REQ-017 PAY: s_axis_tready SHALL equal stage-free; it SHALL be 0 in all other states.
REQ-018 PAY: on each s_axis handshake, SHALL load the word, increment count, and add the word to the checksum modulo 2^DW.
REQ-019 PAY: the payload SHALL end on the handshake where s_axis_tlast=1 or count reaches PAYLOAD_LEN, whichever comes first; the state then goes to TRL.
REQ-020 SHALL set len_error when the final payload word has s_axis_tlast=1 with count<PAYLOAD_LEN, or s_axis_tlast=0 at count==PAYLOAD_LEN; the trailer is still sent.
REQ-021 TRL: when the stage is free, SHALL load the checksum with tlast=1 and go to FIN.
REQ-022 FIN: on the trailer handshake, SHALL clear m_axis_tvalid, pulse frame_done, increment seq (8-bit, wraps 255->0), and go to IDLE.
REQ-023 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-024 Throughput SHALL be 1 payload word per cycle when m_axis_tready=1; input-to-output payload latency is 1 cycle.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the current frame; it only blocks the next start.
REQ-026 s_axis data arriving while not in PAY SHALL be back-pressured, never dropped.

Reset
REQ-027 On rst=1 at a clock edge, SHALL return to IDLE and set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, frame_done=0, len_error=0, busy=0, seq=0, count=0, checksum=0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no trailer; the first frame after reset SHALL carry seq=0.

Verification (PAYLOAD_LEN=4, MAGIC=16'hA55A)
REQ-029 Test: batch_id=3, payload 1,2,3,4 with tlast on 4, m_axis_tready=1 -> output A55A, 0003, 1, 2, 3, 4, 000A (tlast); frame_done pulses once; len_error=0.
REQ-030 Test: second identical frame with batch_id=5 -> info word 0105; checksum 000A.
REQ-031 Test: tlast on the 2nd of payload FFFF,0002 -> output A55A, info, FFFF, 0002, 0001 (tlast); len_error=1 and stays 1.
REQ-032 Test: m_axis_tready toggling 1010... during a frame -> identical word sequence with no duplicates or drops; m_axis_tdata stable while stalled.
REQ-033 Test: rst pulsed after the 2nd payload word -> outputs at reset values the next cycle; the next frame starts with A55A and info seq=0.
REQ-034 Test: enable=0 with s_axis_tvalid=1 -> s_axis_tready=0, m_axis_tvalid=0, busy=0 until enable=1.
